// File: rtl/sdram_port_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
// Holds the FSM encoding, address field layout and the burst-length clamp.
package sdram_port_arb_pkg;

    typedef enum logic [1:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_XFER,
        S_REF
    } state_t;

    localparam int BANK_MSB  = 23;
    localparam int BANK_LSB  = 22;
    localparam int ROW_MSB   = 21;
    localparam int ROW_LSB   = 9;
    localparam int COL_MSB   = 8;
    localparam int COL_LSB   = 0;
    localparam int MAX_BURST = 256;
    localparam int PTR_W     = 2;

    // Zero or oversized lengths become a full 256-word burst.
    function automatic logic [9:0] clamp_len(input logic [9:0] l);
        if (l == 10'd0 || l > 10'(MAX_BURST))
            return 10'(MAX_BURST);
        return l;
    endfunction

endpackage

// File: rtl/sdram_port_arb_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr,
// searching upward with wrap.
module rr_pick
    import sdram_port_arb_pkg::*;
#(
    parameter int NPORT = 3
) (
    input  logic [NPORT-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NPORT-1:0] grant,
    output logic [PTR_W-1:0] idx,
    output logic             vld
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        vld   = 1'b0;
        j     = 0;
        for (int k = 0; k < NPORT; k++) begin
            j = (int'(ptr) + k) % NPORT;
            if (!vld && req[j]) begin
                vld      = 1'b1;
                grant[j] = 1'b1;
                idx      = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/sdram_port_arb.sv
// Round-robin burst arbiter and auto-refresh scheduler in front of the
// SDRAM engine; a pending refresh always beats a client burst.
module sdram_port_arb
    import sdram_port_arb_pkg::*;
#(
    parameter int NPORT      = 3,
    parameter int REF_PERIOD = 390
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init_done,
    input  logic [NPORT-1:0]   req,
    input  logic [NPORT-1:0]   rw_n,
    input  logic [24*NPORT-1:0] addr,
    input  logic [10*NPORT-1:0] len,
    output logic [NPORT-1:0]   gnt,
    output logic [NPORT-1:0]   done,
    output logic               sys_r_wn,
    output logic [23:0]        sys_wraddr,
    output logic [23:0]        sys_rdaddr,
    output logic [9:0]         sdwr_byte,
    output logic [9:0]         sdrd_byte,
    output logic               eng_start,
    output logic               eng_ref,
    input  logic               eng_done,
    output logic               ref_overrun
);

    localparam int TW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

    state_t           state, state_nxt;
    logic             do_grant, do_ref, do_fin, ref_clr;
    logic [NPORT-1:0] pick_oh;
    logic [PTR_W-1:0] pick_idx, rr_ptr, win_idx;
    logic             pick_vld;
    logic [TW-1:0]    timer;
    logic             ref_pend, wrap;
    logic             sel_rd;
    logic [23:0]      sel_addr;
    logic [9:0]       sel_len;

    rr_pick #(.NPORT(NPORT)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (pick_oh),
        .idx   (pick_idx),
        .vld   (pick_vld)
    );

    assign sel_rd   = rw_n[pick_idx];
    assign sel_addr = addr[int'(pick_idx)*24 +: 24];
    assign sel_len  = clamp_len(len[int'(pick_idx)*10 +: 10]);

    // Timer only runs once initialisation has finished.
    assign wrap = (state != S_WAIT_INIT) && (timer == TW'(REF_PERIOD - 1));

    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        do_ref    = 1'b0;
        do_fin    = 1'b0;
        ref_clr   = 1'b0;
        case (state)
            S_WAIT_INIT: if (init_done) state_nxt = S_IDLE;
            S_IDLE: begin
                if (ref_pend) begin
                    do_ref    = 1'b1;
                    state_nxt = S_REF;
                end else if (pick_vld) begin
                    do_grant  = 1'b1;
                    state_nxt = S_XFER;
                end
            end
            S_XFER: if (eng_done) begin
                do_fin    = 1'b1;
                state_nxt = S_IDLE;
            end
            S_REF: if (eng_done) begin
                ref_clr   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_WAIT_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_WAIT_INIT;
            timer       <= '0;
            ref_pend    <= 1'b0;
            ref_overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state != S_WAIT_INIT)
                timer <= wrap ? '0 : timer + 1'b1;
            // A wrap coinciding with refresh completion re-arms without overrun.
            if (wrap) begin
                ref_pend <= 1'b1;
                if (ref_pend && !ref_clr)
                    ref_overrun <= 1'b1;
            end else if (ref_clr) begin
                ref_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt        <= '0;
            done       <= '0;
            eng_start  <= 1'b0;
            eng_ref    <= 1'b0;
            sys_r_wn   <= 1'b1;
            sys_wraddr <= '0;
            sys_rdaddr <= '0;
            sdwr_byte  <= '0;
            sdrd_byte  <= '0;
            rr_ptr     <= '0;
            win_idx    <= '0;
        end else begin
            eng_start <= do_grant;
            eng_ref   <= do_ref;
            done      <= do_fin ? gnt : '0;
            if (do_grant) begin
                gnt      <= pick_oh;
                win_idx  <= pick_idx;
                sys_r_wn <= sel_rd;
                if (sel_rd) begin
                    sys_rdaddr <= sel_addr;
                    sdrd_byte  <= sel_len;
                end else begin
                    sys_wraddr <= sel_addr;
                    sdwr_byte  <= sel_len;
                end
            end else if (do_fin) begin
                gnt <= '0;
            end
            if (do_fin)
                rr_ptr <= (win_idx == PTR_W'(NPORT - 1)) ? '0 : win_idx + 1'b1;
        end
    end

endmodule
